// File: rtl/calc_seq_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// calc_seq_ctrl_pkg
// Shared definitions for the calculator multiply/divide sequencer.
//   - FSM state encoding used by calc_seq_ctrl
//   - operation codes for the op input
// ----------------------------------------------------------------------------
package calc_seq_ctrl_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Operation codes
    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/calc_step_cntr.sv
// ----------------------------------------------------------------------------
// calc_step_cntr
// Iteration counter for the multi-cycle arithmetic loop.
// Ports:
//   clk    in  1         system clock, rising edge
//   reset  in  1         asynchronous, active-high; clears the count
//   clr    in  1         synchronous clear (takes priority over en)
//   en     in  1         advance the count by one
//   full   out 1         count is at its maximum value (2**CNT_BITS-1)
// ----------------------------------------------------------------------------
module calc_step_cntr #(
    parameter int CNT_BITS = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic full
);

    logic [CNT_BITS-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            // Wraps to zero after the last iteration; the value is not reused.
            count <= count + 1'b1;
        end
    end

    assign full = &count;

endmodule

// File: rtl/calc_seq_ctrl.sv
// ----------------------------------------------------------------------------
// calc_seq_ctrl
// Multi-cycle arithmetic sequencer: unsigned shift-add multiply or restoring
// shift-subtract divide, one iteration per clock for WIDTH iterations.
// Handshake: start is sampled only in IDLE; busy is high in LOAD and RUN;
// done pulses for one cycle in DONE. result/err hold until the next
// accepted start.
// Ports:
//   clk     in  1         system clock, rising edge
//   reset   in  1         asynchronous, active-high; clears all state
//   start   in  1         request strobe, sampled only in IDLE
//   op      in  1         0 = multiply, 1 = divide
//   a       in  WIDTH     multiplicand / dividend
//   b       in  WIDTH     multiplier / divisor
//   busy    out 1         high in LOAD and RUN
//   done    out 1         single-cycle pulse in DONE
//   err     out 1         divide-by-zero flag, valid with done
//   result  out 2*WIDTH   mul: product; div: {remainder, quotient}
// ----------------------------------------------------------------------------
module calc_seq_ctrl
    import calc_seq_ctrl_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CNT_BITS = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [2*WIDTH-1:0] result
);

    // FSM state register; kept as a plain named signal so checkers can bind.
    logic [1:0]         state;

    // Operands latched at acceptance
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               op_r;

    // Shared accumulator: mul -> {upper partial sum, multiplier bits}
    //                     div -> {remainder, quotient/dividend bits}
    logic [2*WIDTH-1:0] acc;

    logic               cnt_full;

    // Combinational single-iteration datapath
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] step_next;

    calc_step_cntr #(
        .CNT_BITS (CNT_BITS)
    ) u_step_cntr (
        .clk   (clk),
        .reset (reset),
        .clr   (state == ST_LOAD),
        .en    (state == ST_RUN),
        .full  (cnt_full)
    );

    always_comb begin
        // Multiply: conditionally add multiplicand into the upper half with
        // a carry bit, then shift the (WIDTH+1)+WIDTH pair right by one.
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_r} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};

        // Divide: shift {rem, quo} left and trial-subtract the divisor.
        // div_diff[WIDTH] is the borrow: set means the remainder was smaller.
        div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_trial - {1'b0, b_r};
        if (div_diff[WIDTH]) begin
            div_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end

        step_next = (op_r == OP_DIV) ? div_next : mul_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            a_r    <= '0;
            b_r    <= '0;
            op_r   <= OP_MUL;
            acc    <= '0;
            err    <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_r    <= a;
                        b_r    <= b;
                        op_r   <= op;
                        err    <= 1'b0;
                        result <= '0;
                        state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // Seed the accumulator with the operand that is shifted
                    // out over the iterations; the other half starts cleared.
                    if (op_r == OP_DIV) begin
                        acc <= {{WIDTH{1'b0}}, a_r};
                    end else begin
                        acc <= {{WIDTH{1'b0}}, b_r};
                    end
                    if (op_r == OP_DIV && b_r == '0) begin
                        err    <= 1'b1;
                        result <= '0;
                        state  <= ST_DONE;
                    end else begin
                        err   <= 1'b0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc <= step_next;
                    // The iteration taken while the counter is full is the last.
                    if (cnt_full) begin
                        result <= step_next;
                        state  <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == ST_LOAD) || (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule
